if_fetch_ctrl: RTL

Instruction-fetch sequencer that owns the program counter and drives the instruction-memory request bus. It sequences each fetch as address request, grant, then response. It applies branch redirects, kills in-flight fetches on redirect, and presents fetched instructions to the IF/ID stage with valid/stall flow control. It replaces the free-running PC register: every PC update is gated by bus handshakes and downstream stall.

---
 rtl/if_fetch_ctrl_if.sv | 25 ++
 rtl/if_fetch_ctrl.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/if_fetch_ctrl_if.sv
// Instruction-memory request/response bus between the fetch sequencer and
// instruction memory: address request, grant, then a single response beat.
interface if_fetch_ctrl_if;
  logic        inst_req_o;
  logic [31:0] inst_addr_o;
  logic        inst_gnt_i;
  logic        inst_rvalid_i;
  logic [31:0] inst_rdata_i;

  modport master (
    output inst_req_o,
    output inst_addr_o,
    input  inst_gnt_i,
    input  inst_rvalid_i,
    input  inst_rdata_i
  );

  modport slave (
    input  inst_req_o,
    input  inst_addr_o,
    output inst_gnt_i,
    output inst_rvalid_i,
    output inst_rdata_i
  );
endinterface

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, issues one fetch at a time on the
// instruction bus, handles branch redirects/kills and feeds IF/ID with a skid slot.
module if_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall_i,
  input  logic                   branch_flag_i,
  input  logic [31:0]            branch_target_address_i,
  if_fetch_ctrl_if.master        inst_bus,
  output logic                   if_valid_o,
  output logic [31:0]            if_pc_o,
  output logic [31:0]            if_inst_o
);

  localparam logic [31:0] STEP = 32'(PC_STEP);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_e;

  state_e      state_q;
  logic [31:0] fetch_pc_q, req_pc_q;
  logic        kill_q;
  logic        skid_valid_q;
  logic [31:0] skid_pc_q, skid_inst_q;
  logic        redir_pend_q;
  logic [31:0] redir_tgt_q;
  logic        inst_req_q;
  logic [31:0] inst_addr_q;
  logic        if_valid_q;
  logic [31:0] if_pc_q, if_inst_q;

  logic consume, slot_free;

  always_comb begin
    consume   = if_valid_q && !stall_i;
    slot_free = !if_valid_q || !stall_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      fetch_pc_q   <= RESET_PC;
      req_pc_q     <= '0;
      kill_q       <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_pc_q    <= '0;
      skid_inst_q  <= '0;
      redir_pend_q <= 1'b0;
      redir_tgt_q  <= '0;
      inst_req_q   <= 1'b0;
      inst_addr_q  <= '0;
      if_valid_q   <= 1'b0;
      if_pc_q      <= '0;
      if_inst_q    <= '0;
    end else begin
      // Later assignments below (new loads) override consumption and flush.
      if (consume)       if_valid_q <= 1'b0;
      if (branch_flag_i) begin
        if_valid_q   <= 1'b0;
        skid_valid_q <= 1'b0;
      end

      case (state_q)
        S_IDLE: begin
          state_q    <= S_REQ;
          inst_req_q <= 1'b1;
          if (branch_flag_i) begin
            fetch_pc_q  <= branch_target_address_i;
            inst_addr_q <= branch_target_address_i;
          end else begin
            inst_addr_q <= fetch_pc_q;
          end
        end

        S_REQ: begin
          if (inst_bus.inst_gnt_i) begin
            req_pc_q     <= inst_addr_q;
            inst_req_q   <= 1'b0;
            state_q      <= S_WAIT;
            redir_pend_q <= 1'b0;
            if (branch_flag_i) begin
              kill_q     <= 1'b1;
              fetch_pc_q <= branch_target_address_i;
            end else if (redir_pend_q) begin
              kill_q     <= 1'b1;
              fetch_pc_q <= redir_tgt_q;
            end else begin
              fetch_pc_q <= fetch_pc_q + STEP;
            end
          end else if (branch_flag_i) begin
            // Address must stay put until granted; remember where to go next.
            redir_pend_q <= 1'b1;
            redir_tgt_q  <= branch_target_address_i;
          end
        end

        S_WAIT: begin
          if (inst_bus.inst_rvalid_i) begin
            kill_q <= 1'b0;
            if (branch_flag_i) begin
              fetch_pc_q  <= branch_target_address_i;
              inst_addr_q <= branch_target_address_i;
              inst_req_q  <= 1'b1;
              state_q     <= S_REQ;
            end else if (kill_q || slot_free) begin
              inst_addr_q <= fetch_pc_q;
              inst_req_q  <= 1'b1;
              state_q     <= S_REQ;
              if (!kill_q) begin
                if_valid_q <= 1'b1;
                if_pc_q    <= req_pc_q;
                if_inst_q  <= inst_bus.inst_rdata_i;
              end
            end else begin
              skid_valid_q <= 1'b1;
              skid_pc_q    <= req_pc_q;
              skid_inst_q  <= inst_bus.inst_rdata_i;
              state_q      <= S_HOLD;
            end
          end else if (branch_flag_i) begin
            kill_q     <= 1'b1;
            fetch_pc_q <= branch_target_address_i;
          end
        end

        S_HOLD: begin
          if (branch_flag_i) begin
            fetch_pc_q  <= branch_target_address_i;
            inst_addr_q <= branch_target_address_i;
            inst_req_q  <= 1'b1;
            state_q     <= S_REQ;
          end else if (!stall_i && skid_valid_q) begin
            if_valid_q   <= 1'b1;
            if_pc_q      <= skid_pc_q;
            if_inst_q    <= skid_inst_q;
            skid_valid_q <= 1'b0;
            inst_addr_q  <= fetch_pc_q;
            inst_req_q   <= 1'b1;
            state_q      <= S_REQ;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign inst_bus.inst_req_o  = inst_req_q;
  assign inst_bus.inst_addr_o = inst_addr_q;
  assign if_valid_o           = if_valid_q;
  assign if_pc_o              = if_pc_q;
  assign if_inst_o            = if_inst_q;

endmodule
